// File: rtl/muldiv_if.sv
// muldiv_if: EX-stage handshake bundle for the RV32M multiply/divide sequencer.
// master = EX stage driving the op, slave = the sequencer.
interface muldiv_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;

  modport master (
    output start, funct3, a, b, flush,
    input  stall_o, done_o, result_o
  );

  modport slave (
    input  start, funct3, a, b, flush,
    output stall_o, done_o, result_o
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M shift-add multiply / restoring divide, 64-bit shared acc.
// Optional MULDIV_EARLY_OUT_EN: b==0 or multiply by a==0 skips the BUSY phase.
module muldiv_seq (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [4:0]  r_cnt;
  logic [2:0]  r_f3;
  logic [31:0] r_a;
  logic [31:0] r_opnd;
  logic [63:0] r_acc;
  logic        r_neg_a;
  logic        r_neg_b;
  logic        r_bzero;
  logic [31:0] r_result;

  logic        w_a_sgn;
  logic        w_b_sgn;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_go;
  logic        w_eo;
  logic [31:0] w_eo_res;

  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [32:0] w_div_rem;
  logic [32:0] w_div_diff;
  logic        w_div_ok;
  logic [63:0] w_div_next;
  logic [63:0] w_acc_next;

  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic        w_op_mul;
  logic        w_op_mulh;
  logic        w_op_div;
  logic        w_op_rem;
  logic [31:0] w_res;

  // Operand sign decode: MULHSU treats b as unsigned, *U ops are unsigned.
  always_comb begin
    w_a_sgn = 1'b0;
    w_b_sgn = 1'b0;
    unique case (bus.funct3)
      3'b000: begin w_a_sgn = 1'b1; w_b_sgn = 1'b1; end
      3'b001: begin w_a_sgn = 1'b1; w_b_sgn = 1'b1; end
      3'b010: begin w_a_sgn = 1'b1; w_b_sgn = 1'b0; end
      3'b100: begin w_a_sgn = 1'b1; w_b_sgn = 1'b1; end
      3'b110: begin w_a_sgn = 1'b1; w_b_sgn = 1'b1; end
      default: begin w_a_sgn = 1'b0; w_b_sgn = 1'b0; end
    endcase
  end

  assign w_neg_a = w_a_sgn & bus.a[31];
  assign w_neg_b = w_b_sgn & bus.b[31];
  assign w_a_mag = w_neg_a ? (32'd0 - bus.a) : bus.a;
  assign w_b_mag = w_neg_b ? (32'd0 - bus.b) : bus.b;
  assign w_go    = (r_state == S_IDLE) & bus.start & !bus.flush;

`ifdef MULDIV_EARLY_OUT_EN
  assign w_eo = (bus.b == 32'd0) |
                (!bus.funct3[2] & (bus.a == 32'd0));
`else
  assign w_eo = 1'b0;
`endif

  // Trivial results: multiplies give 0, divides by zero give all-ones / a.
  assign w_eo_res = !bus.funct3[2] ? 32'd0 :
                    bus.funct3[1]  ? bus.a : 32'hFFFF_FFFF;

  // Multiply step: acc = {hi, multiplier}; add multiplicand on lsb, shift right.
  assign w_mul_sum  = {1'b0, r_acc[63:32]} +
                      (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_mul_next = {w_mul_sum, r_acc[31:1]};

  // Divide step: acc = {rem, dividend/quotient}; shift left, trial subtract.
  // rem < divisor holds between steps, so bit 32 of the diff is the borrow.
  assign w_div_rem  = r_acc[63:31];
  assign w_div_diff = w_div_rem - {1'b0, r_opnd};
  assign w_div_ok   = !w_div_diff[32];
  assign w_div_next = w_div_ok ?
                      {w_div_diff[31:0], r_acc[30:0], 1'b1} :
                      {w_div_rem[31:0],  r_acc[30:0], 1'b0};

  assign w_acc_next = r_f3[2] ? w_div_next : w_mul_next;

  // Sign fixup on the value the last step produces.
  assign w_prod = (r_neg_a ^ r_neg_b) ? (64'd0 - w_acc_next) : w_acc_next;
  assign w_quo  = r_bzero ? 32'hFFFF_FFFF :
                  (r_neg_a ^ r_neg_b) ? (32'd0 - w_acc_next[31:0]) :
                  w_acc_next[31:0];
  assign w_rem  = r_bzero ? r_a :
                  r_neg_a ? (32'd0 - w_acc_next[63:32]) :
                  w_acc_next[63:32];

  assign w_op_mul  = (r_f3 == 3'b000);
  assign w_op_mulh = !r_f3[2] & (r_f3[1:0] != 2'b00);
  assign w_op_div  = r_f3[2] & !r_f3[1];
  assign w_op_rem  = r_f3[2] & r_f3[1];

  // Result select by op class.
  always_comb begin
    w_res = 32'd0;
    unique case (1'b1)
      w_op_mul:  w_res = w_prod[31:0];
      w_op_mulh: w_res = w_prod[63:32];
      w_op_div:  w_res = w_quo;
      w_op_rem:  w_res = w_rem;
      default:   w_res = 32'd0;
    endcase
  end

  // Sequencer: IDLE latches operands, BUSY iterates, DONE presents the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 5'd0;
      r_f3     <= 3'd0;
      r_a      <= 32'd0;
      r_opnd   <= 32'd0;
      r_acc    <= 64'd0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_bzero  <= 1'b0;
      r_result <= 32'd0;
    end else if (bus.flush) begin
      r_state <= S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_f3    <= bus.funct3;
            r_a     <= bus.a;
            r_neg_a <= w_neg_a;
            r_neg_b <= w_neg_b;
            r_bzero <= (bus.b == 32'd0);
            r_cnt   <= 5'd31;
            r_opnd  <= bus.funct3[2] ? w_b_mag : w_a_mag;
            r_acc   <= {32'd0, bus.funct3[2] ? w_a_mag : w_b_mag};
            if (w_eo) begin
              r_state  <= S_DONE;
              r_result <= w_eo_res;
            end else begin
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          r_acc <= w_acc_next;
          if (r_cnt == 5'd0) begin
            r_state  <= S_DONE;
            r_result <= w_res;
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.stall_o  = !rst & (w_go | (r_state == S_BUSY));
  assign bus.done_o   = (r_state == S_DONE);
  assign bus.result_o = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed + random RV32M checks against an arithmetic reference.
// Expected latency follows MULDIV_EARLY_OUT_EN when defined.
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_done = 0;

  muldiv_if bus();

  muldiv_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ub, q;
    logic [63:0] p, ua;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    ua = {32'd0, a};
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        q = sa / sb;
        return q[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        q = sa % sb;
        return q[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f3,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (b == 0 || (!f3[2] && a == 0)) return 1;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; leaves start high on the done cycle.
  task automatic run_op(input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input string tag);
    int n;
    bit bad;
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.a      = a;
    bus.b      = b;
    bus.flush  = 1'b0;
    if (bus.done_o) @(negedge clk);
    #1;
    check({tag, "_t0stall"}, 32'(bus.stall_o), 32'd1);
    n = 0;
    bad = 1'b0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (bus.done_o) break;
      if (bus.stall_o !== 1'b1) bad = 1'b1;
    end
    last_done = cyc;
    check({tag, "_lat"}, 32'(n), 32'(exp_lat(f3, a, b)));
    check({tag, "_busystall"}, 32'(bad), 32'd0);
    check({tag, "_donestall"}, 32'(bus.stall_o), 32'd0);
    check({tag, "_res"}, bus.result_o, ref_op(f3, a, b));
  endtask

  task automatic idle(input int k);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] prev;
    bit          seen;
    int          d1;
    logic [2:0]  rf3;
    logic [31:0] ra, rb;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.funct3 = 3'd0;
    bus.a = 32'd0;
    bus.b = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_stall", 32'(bus.stall_o), 32'd0);
    check("rst_done", 32'(bus.done_o), 32'd0);
    check("rst_res", bus.result_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul7");
    check("mul7_val", bus.result_o, 32'hFFFF_FFEB);
    idle(1);
    check("done_pulse", 32'(bus.done_o), 32'd0);
    check("res_hold", bus.result_o, 32'hFFFF_FFEB);

    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh");   idle(1);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");  idle(1);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu"); idle(1);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf"); idle(1);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf"); idle(1);
    run_op(3'd4, 32'hFFFF_FFEC, 32'd6, "div_neg");        idle(1);
    run_op(3'd6, 32'hFFFF_FFEC, 32'd6, "rem_neg");        idle(1);
    run_op(3'd5, 32'h0000_1234, 32'd0, "divu_z");         idle(1);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd0, "rem_z");          idle(1);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd0, "div_z");          idle(1);
    run_op(3'd0, 32'd0, 32'd12345, "mul_a0");             idle(1);

    prev = bus.result_o;
    seen = 1'b0;
    bus.start = 1'b1;
    bus.funct3 = 3'd4;
    bus.a = 32'd1000;
    bus.b = 32'd3;
    repeat (10) begin
      @(negedge clk);
      if (bus.done_o) seen = 1'b1;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    if (bus.done_o) seen = 1'b1;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    #1;
    check("flush_stall", 32'(bus.stall_o), 32'd0);
    check("flush_nodone", 32'(seen), 32'd0);
    check("flush_hold", bus.result_o, prev);
    run_op(3'd7, 32'd100, 32'd7, "remu_post");
    check("remu_post_val", bus.result_o, 32'd2);
    idle(1);

    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.funct3 = 3'd0;
    bus.a = 32'd3;
    bus.b = 32'd5;
    #1;
    check("flush_t0_stall", 32'(bus.stall_o), 32'd0);
    @(negedge clk);
    idle(1);
    check("flush_t0_done", 32'(bus.done_o), 32'd0);
    check("flush_t0_stall2", 32'(bus.stall_o), 32'd0);

    bus.start = 1'b1;
    bus.funct3 = 3'd0;
    bus.a = 32'd123;
    bus.b = 32'd456;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_stall", 32'(bus.stall_o), 32'd0);
    check("rstmid_done", 32'(bus.done_o), 32'd0);
    check("rstmid_res", bus.result_o, 32'd0);
    rst = 1'b0;
    idle(1);
    check("rstmid_idle", 32'(bus.done_o), 32'd0);

    run_op(3'd0, 32'd123, 32'd456, "b2b1");
    d1 = last_done;
    run_op(3'd0, 32'hFFFF_FF00, 32'd77, "b2b2");
    check("b2b_gap", 32'(last_done - d1), 32'd34);
    idle(1);

    for (int i = 0; i < 40; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      run_op(rf3, ra, rb, $sformatf("rnd%0d_f%0d", i, rf3));
      idle($urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
